// File: rtl/spi_frame_rx.sv
// ============================================================================
// spi_frame_rx
// ----------------------------------------------------------------------------
// SPI slave receiver for multi-word frames. It sits between the off-board SPI
// pins (MCU/camera configuration link) and the register/pixel consumers in
// the clk_in domain. All four SPI modes are supported (CPOL/CPHA), the bit
// order is selectable, and each frame carries FRAME_WORDS words of DATA_WIDTH
// bits while sel_in is held low.
//
// Optional feature macro: SPI_RX_SYNC_EN
//   defined     : data_in, data_clk_in and sel_in each pass through a 2-flop
//                 synchroniser (adds 2 cycles of latency, keeps the relative
//                 timing between the pins).
//   not defined : pins are used directly and must be synchronous to clk_in.
//
// Ports
//   clk_in          system clock (oversamples SCLK, SCLK <= clk_in/4)
//   rst_in          synchronous active-high reset
//   data_in         serial data (MOSI)
//   data_clk_in     serial clock (SCLK)
//   sel_in          chip select, active low
//   data_out        last complete word, held until the next word
//   new_data_out    1-cycle pulse: data_out / word_idx_out just updated
//   word_idx_out    position of data_out inside its frame
//   frame_done_out  1-cycle pulse alongside the last word of a frame
//   frame_err_out   1-cycle pulse: sel_in rose in the middle of a frame
// ============================================================================
module spi_frame_rx #(
    parameter int DATA_WIDTH  = 10,
    parameter int FRAME_WORDS = 4,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data_out,
    output logic [IW-1:0]         word_idx_out,
    output logic                  frame_done_out,
    output logic                  frame_err_out
);

    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic d_s;
    logic clk_s;
    logic sel_s;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] d_sync_q;
    logic [1:0] clk_sync_q;
    logic [1:0] sel_sync_q;

    // Reset values match the idle state of the link so that no spurious
    // edge or select is seen when reset is released.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            d_sync_q   <= 2'b00;
            clk_sync_q <= {2{CPOL}};
            sel_sync_q <= 2'b11;
        end else begin
            d_sync_q   <= {d_sync_q[0], data_in};
            clk_sync_q <= {clk_sync_q[0], data_clk_in};
            sel_sync_q <= {sel_sync_q[0], sel_in};
        end
    end

    assign d_s   = d_sync_q[1];
    assign clk_s = clk_sync_q[1];
    assign sel_s = sel_sync_q[1];
`else
    assign d_s   = data_in;
    assign clk_s = data_clk_in;
    assign sel_s = sel_in;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic                  prev_clk_q,   prev_clk_d;
    logic [BW-1:0]         bit_cnt_q,    bit_cnt_d;
    logic [IW-1:0]         word_cnt_q,   word_cnt_d;
    logic [DATA_WIDTH-1:0] sr_q,         sr_d;
    logic                  word_rdy_q,   word_rdy_d;
    logic [DATA_WIDTH-1:0] data_q,       data_d;
    logic                  new_data_q,   new_data_d;
    logic [IW-1:0]         word_idx_q,   word_idx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q,  frame_err_d;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the
    // falling one.
    logic sample_edge;
    assign sample_edge = ((CPOL ^ CPHA) == 1'b0) ? (clk_s & ~prev_clk_q)
                                                 : (~clk_s & prev_clk_q);

    always_comb begin
        state_d      = state_q;
        prev_clk_d   = clk_s;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        sr_d         = sr_q;
        word_rdy_d   = 1'b0;
        data_d       = data_q;
        new_data_d   = 1'b0;
        word_idx_d   = word_idx_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        // A word completed on the previous sample edge is published one
        // cycle later; the shift register is stable by then.
        if (word_rdy_q) begin
            data_d     = sr_q;
            word_idx_d = word_cnt_q;
            new_data_d = 1'b1;
            if (word_cnt_q == IW'(FRAME_WORDS - 1)) begin
                word_cnt_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + IW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                if (!sel_s) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (sel_s) begin
                    // Deselect wins over a coincident sample edge. A word that
                    // already completed is still published; only the partial
                    // word is dropped.
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0) || (word_cnt_d != '0);
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                end else if (sample_edge) begin
                    if (MSB_FIRST) begin
                        sr_d = {sr_q[DATA_WIDTH-2:0], d_s};
                    end else begin
                        sr_d = {d_s, sr_q[DATA_WIDTH-1:1]};
                    end
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        word_rdy_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            prev_clk_q   <= CPOL;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sr_q         <= '0;
            word_rdy_q   <= 1'b0;
            data_q       <= '0;
            new_data_q   <= 1'b0;
            word_idx_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_clk_q   <= prev_clk_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sr_q         <= sr_d;
            word_rdy_q   <= word_rdy_d;
            data_q       <= data_d;
            new_data_q   <= new_data_d;
            word_idx_q   <= word_idx_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out       = data_q;
    assign new_data_out   = new_data_q;
    assign word_idx_out   = word_idx_q;
    assign frame_done_out = frame_done_q;
    assign frame_err_out  = frame_err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// ============================================================================
// tb_spi_frame_rx
// ----------------------------------------------------------------------------
// Testbench for spi_frame_rx. dut0 runs mode 0, MSB first; dut3 runs mode 3,
// LSB first. Both share data_in and sel_in and have their own SCLK.
// ============================================================================
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       sclk0;
    logic       sclk3;
    logic       sel;

    logic [9:0] data0, data3;
    logic       new0, new3;
    logic [1:0] idx0, idx3;
    logic       done0, done3;
    logic       err0, err3;

    always #5 clk = ~clk;

    spi_frame_rx #(
        .DATA_WIDTH (10),
        .FRAME_WORDS(4),
        .CPOL       (1'b0),
        .CPHA       (1'b0),
        .MSB_FIRST  (1'b1)
    ) dut0 (
        .clk_in        (clk),
        .rst_in        (rst),
        .data_in       (din),
        .data_clk_in   (sclk0),
        .sel_in        (sel),
        .data_out      (data0),
        .new_data_out  (new0),
        .word_idx_out  (idx0),
        .frame_done_out(done0),
        .frame_err_out (err0)
    );

    spi_frame_rx #(
        .DATA_WIDTH (10),
        .FRAME_WORDS(4),
        .CPOL       (1'b1),
        .CPHA       (1'b1),
        .MSB_FIRST  (1'b0)
    ) dut3 (
        .clk_in        (clk),
        .rst_in        (rst),
        .data_in       (din),
        .data_clk_in   (sclk3),
        .sel_in        (sel),
        .data_out      (data3),
        .new_data_out  (new3),
        .word_idx_out  (idx3),
        .frame_done_out(done3),
        .frame_err_out (err3)
    );

`ifdef SPI_RX_SYNC_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct {
        logic [9:0] data;
        logic [1:0] idx;
        logic       done;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [9:0] word;
        logic [1:0] idx;
        logic       done;
    } vec_t;

    ev_t  q0[$];
    ev_t  q3[$];
    int   cyc = 0;
    int   edge_cyc = 0;
    int   err0_cnt = 0, err3_cnt = 0;
    int   dbl_cnt = 0, stray_cnt = 0;
    logic new0_prev = 1'b0, new3_prev = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_err0 = 0, exp_err3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records every published word and pulse anomalies.
    always @(negedge clk) begin
        if (!rst) begin
            if (new0) q0.push_back('{data0, idx0, done0, cyc});
            if (new3) q3.push_back('{data3, idx3, done3, cyc});
            if (err0) err0_cnt <= err0_cnt + 1;
            if (err3) err3_cnt <= err3_cnt + 1;
            if ((new0 && new0_prev) || (new3 && new3_prev)) dbl_cnt <= dbl_cnt + 1;
            if ((done0 && !new0) || (done3 && !new3)) stray_cnt <= stray_cnt + 1;
        end
        new0_prev <= new0;
        new3_prev <= new3;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit: data set together with the leading edge; mode 0 samples on
    // the leading (rising) edge, mode 3 on the trailing (rising) edge.
    task automatic send_bit(input int which, input logic b);
        din = b;
        if (which == 0) begin
            sclk0 = 1'b1;
            edge_cyc = cyc;
            tick(2);
            sclk0 = 1'b0;
            tick(2);
        end else begin
            sclk3 = 1'b0;
            tick(2);
            sclk3 = 1'b1;
            edge_cyc = cyc;
            tick(2);
        end
    endtask

    task automatic send_bits(input int which, input logic [9:0] w, input bit lsb_first, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(which, lsb_first ? w[i] : w[9-i]);
        end
    endtask

    task automatic expect_word(input int which, input logic [9:0] ed, input logic [1:0] ei,
                               input logic edn, input int chk_lat, input string nm);
        ev_t e;
        int  n;
        n = (which == 0) ? q0.size() : q3.size();
        chk({nm, "_count"}, n, 1);
        if (n > 0) begin
            if (which == 0) e = q0.pop_front();
            else            e = q3.pop_front();
            chk({nm, "_data"}, {22'd0, e.data}, {22'd0, ed});
            chk({nm, "_idx"},  {30'd0, e.idx},  {30'd0, ei});
            chk({nm, "_done"}, {31'd0, e.done}, {31'd0, edn});
            if (chk_lat != 0) chk({nm, "_latency"}, e.cyc - edge_cyc, EXP_LAT);
        end
        q0.delete();
        q3.delete();
    endtask

    task automatic deselect(input string nm);
        sel = 1'b1;
        tick(4);
        chk({nm, "_err0"}, err0_cnt, exp_err0);
        chk({nm, "_err3"}, err3_cnt, exp_err3);
    endtask

    vec_t tbl[6];

    initial begin
        // T1 + T4: six words with sel low -> idx 0,1,2,3,0,1, one frame_done.
        tbl[0] = '{10'h2A5, 2'd0, 1'b0};
        tbl[1] = '{10'h133, 2'd1, 1'b0};
        tbl[2] = '{10'h0F0, 2'd2, 1'b0};
        tbl[3] = '{10'h3FF, 2'd3, 1'b1};
        tbl[4] = '{10'h001, 2'd0, 1'b0};
        tbl[5] = '{10'h155, 2'd1, 1'b0};

        rst = 1'b1; din = 1'b0; sclk0 = 1'b0; sclk3 = 1'b1; sel = 1'b1;
        tick(3);
        chk("reset_dut0", {17'd0, data0, new0, idx0, done0, err0}, 32'd0);
        chk("reset_dut3", {17'd0, data3, new3, idx3, done3, err3}, 32'd0);
        rst = 1'b0;
        tick(3);

        // T1/T4
        sel = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            send_bits(0, tbl[i].word, 1'b0, 10);
            tick(2);
            expect_word(0, tbl[i].word, tbl[i].idx, tbl[i].done, (i == 0) ? 1 : 0,
                        $sformatf("t1_w%0d", i));
        end
        exp_err0++;
        deselect("t4_desel");
        chk("t4_data_hold", {22'd0, data0}, 32'h155);

        // T2: mode 3, LSB first, first bit 1 then nine zeros -> 0x001.
        sel = 1'b0;
        tick(2);
        send_bits(1, 10'h001, 1'b1, 10);
        tick(2);
        expect_word(1, 10'h001, 2'd0, 1'b0, 0, "t2_w0");
        exp_err3++;
        deselect("t2_desel");

        // T3: abort after 5 bits, then a clean full frame.
        sel = 1'b0;
        tick(2);
        send_bits(0, 10'h3C3, 1'b0, 5);
        exp_err0++;
        deselect("t3_abort");
        chk("t3_no_word", q0.size(), 0);
        chk("t3_data_hold", {22'd0, data0}, 32'h155);
        sel = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            send_bits(0, tbl[i].word, 1'b0, 10);
            tick(2);
            expect_word(0, tbl[i].word, tbl[i].idx, tbl[i].done, 0, $sformatf("t3_w%0d", i));
        end
        deselect("t3_clean_end");

        // T5: reset mid-word 2, then bits resume from idx 0.
        sel = 1'b0;
        tick(2);
        send_bits(0, tbl[0].word, 1'b0, 10);
        send_bits(0, tbl[1].word, 1'b0, 10);
        send_bits(0, 10'h2DB, 1'b0, 4);
        q0.delete();
        rst = 1'b1;
        tick(1);
        chk("t5_reset_out", {17'd0, data0, new0, idx0, done0, err0}, 32'd0);
        rst = 1'b0;
        tick(4);
        send_bits(0, 10'h0F0, 1'b0, 10);
        tick(2);
        expect_word(0, 10'h0F0, 2'd0, 1'b0, 0, "t5_w0");
        exp_err0++;
        deselect("t5_desel");

        // T6: sample edge coincident with sel rise -> edge ignored.
        sel = 1'b0;
        tick(2);
        send_bits(0, 10'h3FF, 1'b0, 3);
        din = 1'b1;
        sclk0 = 1'b1;
        sel = 1'b1;
        tick(2);
        sclk0 = 1'b0;
        tick(2);
        exp_err0++;
        chk("t6_err0", err0_cnt, exp_err0);
        chk("t6_no_word", q0.size(), 0);
        sel = 1'b0;
        tick(2);
        send_bits(0, 10'h24A, 1'b0, 10);
        tick(2);
        expect_word(0, 10'h24A, 2'd0, 1'b0, 0, "t6_w0");
        exp_err0++;
        deselect("t6_desel");

        chk("pulse_width", dbl_cnt, 0);
        chk("stray_done", stray_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
